// File: rtl/cmem_fill.sv
// cmem_fill: refills one cache line from the 64-bit system read bus and returns it to cmem.
// Macro CMEM_FILL_BURST_EN selects a single burst request per line; when it is undefined,
// each beat is fetched with its own single-beat request.
module cmem_fill #(
  parameter int LINE_W  = 512,
  parameter int BUS_W   = 64,
  parameter int BLK_LEN = 58
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BLK_LEN-1:0] b_addr_c,
  input  logic               b_rd_c,
  output logic [LINE_W-1:0]  b_rdata_c,
  output logic               b_dv_c,
  output logic [63:0]        m_addr,
  output logic [7:0]         m_blen,
  output logic               m_rd,
  input  logic               m_gnt,
  input  logic [BUS_W-1:0]   m_rdata,
  input  logic               m_rvalid
);
  localparam int BEATS = LINE_W / BUS_W;
  localparam int CW    = $clog2(BEATS) + 1;
  localparam int OFF   = 64 - BLK_LEN;
  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_e;
  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [63:0]     base_d;
  logic            last_beat;
  assign base_d    = {b_addr_c, {OFF{1'b0}}};
  assign cnt_d     = cnt_q + 1'b1;
  assign last_beat = cnt_q == CW'(BEATS - 1);
  // Fill sequencer: m_addr holds the line base on entry to REQ and steps one beat per re-request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      b_rdata_c <= '0;
      b_dv_c    <= 1'b0;
      m_rd      <= 1'b0;
      m_addr    <= '0;
      m_blen    <= '0;
    end else begin
      case (state_q)
        IDLE: if (b_rd_c) begin
          cnt_q   <= '0;
          m_rd    <= 1'b1;
          m_addr  <= base_d;
`ifdef CMEM_FILL_BURST_EN
          m_blen  <= 8'(BEATS - 1);
`else
          m_blen  <= 8'd0;
`endif
          state_q <= REQ;
        end
        REQ: if (m_gnt) begin
          m_rd    <= 1'b0;
          state_q <= DATA;
        end
        DATA: if (m_rvalid) begin
          for (int k = 0; k < BEATS; k++)
            if (cnt_q == CW'(k)) b_rdata_c[BUS_W*k +: BUS_W] <= m_rdata;
          cnt_q <= cnt_d;
          if (last_beat) begin
            b_dv_c  <= 1'b1;
            state_q <= DONE;
          end
`ifndef CMEM_FILL_BURST_EN
          else begin
            m_rd    <= 1'b1;
            m_addr  <= m_addr + 64'(BUS_W / 8);
            state_q <= REQ;
          end
`endif
        end
        DONE: begin
          b_dv_c  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cmem_fill.sv
// tb_cmem_fill: directed fills of cmem_fill with a queue-based scoreboard for bus requests and returned lines.
module tb_cmem_fill;
`ifdef CMEM_FILL_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  localparam int NREQ = BURST ? 1 : 8;
  localparam int BPR  = BURST ? 8 : 1;
  localparam int LAT  = BURST ? 10 : 17;
  localparam int BLEN = BURST ? 7 : 0;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [57:0]  b_addr_c = '0;
  logic         b_rd_c = 1'b0;
  logic [511:0] b_rdata_c;
  logic         b_dv_c;
  logic [63:0]  m_addr;
  logic [7:0]   m_blen;
  logic         m_rd;
  logic         m_gnt = 1'b0;
  logic [63:0]  m_rdata = '0;
  logic         m_rvalid = 1'b0;
  int total = 0, bad = 0, cyc = 0;
  logic [71:0]  req_q[$];
  logic [511:0] line_q[$];
  int           dvc_q[$];
  cmem_fill dut (
    .clk(clk), .rst_n(rst_n), .b_addr_c(b_addr_c), .b_rd_c(b_rd_c),
    .b_rdata_c(b_rdata_c), .b_dv_c(b_dv_c), .m_addr(m_addr), .m_blen(m_blen),
    .m_rd(m_rd), .m_gnt(m_gnt), .m_rdata(m_rdata), .m_rvalid(m_rvalid)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask
  task automatic flag(input string nm);
    total++;
    bad++;
    $display("FAIL %s got=event want=none", nm);
  endtask
  // Monitor: checks each accepted request, each returned line and its cycle, and request stability while stalled.
  logic        prev_rd = 1'b0, prev_dv = 1'b0;
  logic [63:0] prev_addr = '0;
  logic [7:0]  prev_blen = '0;
  always @(negedge clk) begin
    logic [71:0] e;
    if (!rst_n) begin
      prev_rd = 1'b0;
      prev_dv = 1'b0;
    end else begin
      if (m_rd && prev_rd) begin
        chk("hold_addr", 512'(m_addr), 512'(prev_addr));
        chk("hold_blen", 512'(m_blen), 512'(prev_blen));
      end
      if (m_rd && m_gnt) begin
        if (req_q.size() == 0) flag("unexpected_req");
        else begin
          e = req_q.pop_front();
          chk("req_addr", 512'(m_addr), 512'(e[71:8]));
          chk("req_blen", 512'(m_blen), 512'(e[7:0]));
        end
      end
      if (b_dv_c) begin
        if (prev_dv) flag("dv_width");
        if (line_q.size() == 0) flag("unexpected_dv");
        else begin
          chk("line", b_rdata_c, line_q.pop_front());
          chk("dv_cycle", 512'(cyc), 512'(dvc_q.pop_front()));
        end
      end
      prev_rd   = m_rd && !m_gnt;
      prev_addr = m_addr;
      prev_blen = m_blen;
      prev_dv   = b_dv_c;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // One line fill: acts as cmem and as the bus; abort_at >= 0 resets the DUT after that beat.
  task automatic fill(input logic [57:0] a, input int gw, input logic [63:0] seed, input int abort_at);
    logic [63:0]  base;
    logic [511:0] line;
    int n;
    base = {a, 6'b0};
    for (int k = 0; k < 8; k++) line[64*k +: 64] = seed + 64'(k);
    b_addr_c = a;
    b_rd_c = 1'b1;
    if (abort_at < 0) begin
      line_q.push_back(line);
      dvc_q.push_back(cyc + LAT + gw * NREQ);
    end
    for (int r = 0; r < NREQ; r++) begin
      n = 0;
      while (!m_rd && n < 20) begin step(); n++; end
      if (!m_rd) begin flag("rd_timeout"); return; end
      req_q.push_back({BURST ? base : base + 64'(8 * r), 8'(BLEN)});
      repeat (gw) step();
      m_gnt = 1'b1;
      step();
      m_gnt = 1'b0;
      for (int j = 0; j < BPR; j++) begin
        m_rvalid = 1'b1;
        m_rdata = seed + 64'(r * BPR + j);
        step();
        m_rvalid = 1'b0;
        if (r * BPR + j == abort_at) begin
          rst_n = 1'b0;
          b_rd_c = 1'b0;
          #1;
          chk("abort_dv", 512'(b_dv_c), 512'(0));
          chk("abort_rd", 512'(m_rd), 512'(0));
          chk("abort_line", b_rdata_c, 512'(0));
          step();
          rst_n = 1'b1;
          return;
        end
      end
    end
    n = 0;
    while (!b_dv_c && n < 40) begin step(); n++; end
    if (!b_dv_c) flag("dv_timeout");
    step();
    b_rd_c = 1'b0;
  endtask
  initial begin
    repeat (4) begin
      b_addr_c = {$urandom, $urandom};
      b_rd_c   = 1'($urandom);
      m_gnt    = 1'($urandom);
      m_rvalid = 1'($urandom);
      m_rdata  = {$urandom, $urandom};
      step();
      chk("rst_dv", 512'(b_dv_c), 512'(0));
      chk("rst_rd", 512'(m_rd), 512'(0));
      chk("rst_addr", 512'(m_addr), 512'(0));
      chk("rst_blen", 512'(m_blen), 512'(0));
      chk("rst_line", b_rdata_c, 512'(0));
    end
    b_rd_c = 1'b0;
    m_gnt = 1'b0;
    m_rvalid = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (10) begin
      step();
      chk("idle_rd", 512'(m_rd), 512'(0));
    end
    fill(58'h1, 0, 64'h0, -1);
    repeat (3) step();
    fill(58'h1, 5, 64'h100, -1);
    repeat (3) step();
    fill(58'h40, 0, 64'hA000, -1);
    repeat (3) step();
    fill(58'h3, 0, 64'hB000, 3);
    m_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    m_rvalid = 1'b1;
    repeat (3) step();
    m_rvalid = 1'b0;
    fill(58'h2, 1, 64'hC000, -1);
    repeat (3) step();
    fill(58'h5, 0, 64'hD000, -1);
    fill(58'h6, 0, 64'hE000, -1);
    repeat (5) step();
    chk("req_left", 512'(req_q.size()), 512'(0));
    chk("line_left", 512'(line_q.size()), 512'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
endmodule
